// File: rtl/bsg_manycore_link_sram_responder_pkg.sv
// Shared manycore link definitions: request/response type encodings and the
// link bundle width derived from the mesh parameters.
package bsg_manycore_link_sram_responder_pkg;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_e;

    typedef enum logic {
        RSP_LOAD_DATA = 1'b0,
        RSP_STORE_ACK = 1'b1
    } rsp_type_e;

    localparam int OOB_COUNT_WIDTH = 16;

    // Request layout, MSB first: op, addr, mask, data, src_y, src_x, load_id.
    function automatic int req_packet_width(int x, int y, int d, int a, int l);
        return 1 + a + d / 8 + d + y + x + l;
    endfunction

    // Response layout, MSB first: type, data, load_id, dst_y, dst_x, src_y, src_x.
    function automatic int rsp_packet_width(int x, int y, int d, int l);
        return 1 + d + l + 2 * (x + y);
    endfunction

    // Bundle layout, MSB first: fwd_v, fwd_pkt, fwd_ready, rev_v, rev_pkt, rev_ready.
    function automatic int link_sif_width(int x, int y, int d, int a, int l);
        return 4 + req_packet_width(x, y, d, a, l) + rsp_packet_width(x, y, d, l);
    endfunction

endpackage

// File: rtl/bsg_manycore_link_sram_responder_sram.sv
// Single-port synchronous SRAM with byte-masked writes and a registered
// one-cycle read; contents are never reset.
module bsg_manycore_responder_sram #(
    parameter int els_p        = 1024,
    parameter int width_p      = 32,
    parameter int addr_width_p = 10
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic                   we,
    input  logic [addr_width_p-1:0] addr,
    input  logic [width_p-1:0]     wdata,
    input  logic [width_p/8-1:0]   mask,
    output logic [width_p-1:0]     rdata
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < width_p / 8; i++) begin
                    if (mask[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/bsg_manycore_link_sram_responder.sv
// Memory-side link endpoint: buffers remote load/store requests, performs them
// on a local SRAM and returns one in-order response per request.
module bsg_manycore_link_sram_responder
    import bsg_manycore_link_sram_responder_pkg::*;
#(
    parameter int x_cord_width_p   = -1,
    parameter int y_cord_width_p   = -1,
    parameter int data_width_p     = 32,
    parameter int addr_width_p     = -1,
    parameter int load_id_width_p  = 5,
    parameter int mem_els_p        = 1024,
    localparam int bsg_manycore_link_sif_width_lp = link_sif_width(x_cord_width_p,
        y_cord_width_p, data_width_p, addr_width_p, load_id_width_p)
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic [bsg_manycore_link_sif_width_lp-1:0] link_sif_i,
    output logic [bsg_manycore_link_sif_width_lp-1:0] link_sif_o,
    input  logic [x_cord_width_p-1:0]                 my_x_i,
    input  logic [y_cord_width_p-1:0]                 my_y_i,
    output logic [OOB_COUNT_WIDTH-1:0]                oob_count_o
);

    localparam int idx_width_lp = $clog2(mem_els_p);

    typedef struct packed {
        op_e                        op;
        logic [addr_width_p-1:0]    addr;
        logic [data_width_p/8-1:0]  mask;
        logic [data_width_p-1:0]    data;
        logic [y_cord_width_p-1:0]  src_y;
        logic [x_cord_width_p-1:0]  src_x;
        logic [load_id_width_p-1:0] load_id;
    } req_s;

    typedef struct packed {
        rsp_type_e                  rtype;
        logic [data_width_p-1:0]    data;
        logic [load_id_width_p-1:0] load_id;
        logic [y_cord_width_p-1:0]  dst_y;
        logic [x_cord_width_p-1:0]  dst_x;
        logic [y_cord_width_p-1:0]  src_y;
        logic [x_cord_width_p-1:0]  src_x;
    } rsp_s;

    typedef struct packed {
        logic fwd_v;
        req_s fwd_pkt;
        logic fwd_ready;
        logic rev_v;
        rsp_s rev_pkt;
        logic rev_ready;
    } link_s;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    link_s  link_in, link_out;
    state_e state, state_next;

    req_s       fifo_mem [2];
    logic       wr_ptr, rd_ptr;
    logic [1:0] count, count_next;
    logic       fwd_ready_r;
    logic       push, pop;

    req_s head;
    logic head_oob;

    op_e                        cur_op;
    logic                       cur_oob;
    logic [y_cord_width_p-1:0]  cur_src_y;
    logic [x_cord_width_p-1:0]  cur_src_x;
    logic [load_id_width_p-1:0] cur_load_id;

    rsp_s                       resp_r;
    logic [data_width_p-1:0]    sram_rdata;
    logic [OOB_COUNT_WIDTH-1:0] oob_count;
    logic                       unused_link_bits;

    assign link_in          = link_sif_i;
    assign unused_link_bits = ^{link_in.fwd_ready, link_in.rev_v, link_in.rev_pkt};

    assign head       = fifo_mem[rd_ptr];
    assign head_oob   = 32'(head.addr) >= 32'(mem_els_p);
    assign push       = link_in.fwd_v & fwd_ready_r;
    assign count_next = count + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != 2'd0) begin
                    pop        = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: state_next = RESP;
            RESP: begin
                if (link_in.rev_ready) begin
                    if (count != 2'd0) begin
                        pop        = 1'b1;
                        state_next = ACCESS;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= link_in.fwd_pkt;
        end
    end

    // Ready comes from the registered occupancy so a full FIFO never sees push and pop together.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            fwd_ready_r <= 1'b0;
            cur_op      <= OP_LOAD;
            cur_oob     <= 1'b0;
            cur_src_y   <= '0;
            cur_src_x   <= '0;
            cur_load_id <= '0;
            resp_r      <= '0;
            oob_count   <= '0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            fwd_ready_r <= (count_next != 2'd2);
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) begin
                rd_ptr      <= ~rd_ptr;
                cur_op      <= head.op;
                cur_oob     <= head_oob;
                cur_src_y   <= head.src_y;
                cur_src_x   <= head.src_x;
                cur_load_id <= head.load_id;
                if (head_oob && oob_count != '1) begin
                    oob_count <= oob_count + 16'd1;
                end
            end
            if (state == ACCESS) begin
                resp_r.rtype   <= (cur_op == OP_STORE) ? RSP_STORE_ACK : RSP_LOAD_DATA;
                resp_r.data    <= (cur_op == OP_STORE || cur_oob) ? '0 : sram_rdata;
                resp_r.load_id <= cur_load_id;
                resp_r.dst_y   <= cur_src_y;
                resp_r.dst_x   <= cur_src_x;
                resp_r.src_y   <= my_y_i;
                resp_r.src_x   <= my_x_i;
            end
        end
    end

    bsg_manycore_responder_sram #(
        .els_p       (mem_els_p),
        .width_p     (data_width_p),
        .addr_width_p(idx_width_lp)
    ) sram (
        .clk  (clk_i),
        .en   (pop & ~head_oob),
        .we   (head.op == OP_STORE),
        .addr (head.addr[idx_width_lp-1:0]),
        .wdata(head.data),
        .mask (head.mask),
        .rdata(sram_rdata)
    );

    always_comb begin
        link_out           = '0;
        link_out.fwd_ready = fwd_ready_r;
        link_out.rev_v     = (state == RESP);
        link_out.rev_pkt   = resp_r;
    end

    assign link_sif_o  = link_out;
    assign oob_count_o = oob_count;

endmodule

// File: tb/tb_bsg_manycore_link_sram_responder.sv
// Scoreboard bench for the SRAM responder: directed vectors push expected
// responses, a monitor pops and compares each handshaken response.
module tb_bsg_manycore_link_sram_responder;
    import bsg_manycore_link_sram_responder_pkg::*;

    localparam int XW = 4, YW = 4, DW = 32, AW = 10, LW = 5, ELS = 64;
    localparam int LINKW = link_sif_width(XW, YW, DW, AW, LW);
    localparam logic [XW-1:0] MY_X = 4'd3;
    localparam logic [YW-1:0] MY_Y = 4'd6;

    typedef struct packed {
        logic          op;
        logic [AW-1:0] addr;
        logic [3:0]    mask;
        logic [DW-1:0] data;
        logic [YW-1:0] src_y;
        logic [XW-1:0] src_x;
        logic [LW-1:0] load_id;
    } req_s;

    typedef struct packed {
        logic          rtype;
        logic [DW-1:0] data;
        logic [LW-1:0] load_id;
        logic [YW-1:0] dst_y;
        logic [XW-1:0] dst_x;
        logic [YW-1:0] src_y;
        logic [XW-1:0] src_x;
    } rsp_s;

    typedef struct packed {
        logic fwd_v;
        req_s fwd_pkt;
        logic fwd_ready;
        logic rev_v;
        rsp_s rev_pkt;
        logic rev_ready;
    } link_s;

    typedef struct {
        rsp_s pkt;
        int   due;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [LINKW-1:0] link_sif_i, link_sif_o;
    link_s            link_in, link_out;
    logic [XW-1:0]    my_x = MY_X;
    logic [YW-1:0]    my_y = MY_Y;
    logic [15:0]      oob_count;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_accept;
    int            held_bad;
    int            bad_intervals;
    int            acc_cyc [64];
    exp_t          exp_q [$];
    logic [DW-1:0] model_mem [ELS];

    assign link_sif_i = link_in;
    assign link_out   = link_sif_o;

    bsg_manycore_link_sram_responder #(
        .x_cord_width_p (XW),
        .y_cord_width_p (YW),
        .data_width_p   (DW),
        .addr_width_p   (AW),
        .load_id_width_p(LW),
        .mem_els_p      (ELS)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .link_sif_i (link_sif_i),
        .link_sif_o (link_sif_o),
        .my_x_i     (my_x),
        .my_y_i     (my_y),
        .oob_count_o(oob_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drives one request, waits for acceptance and queues the expected response.
    task automatic applyStimulus(input logic op, input logic [AW-1:0] addr, input logic [3:0] mask,
                                 input logic [DW-1:0] data, input logic [XW-1:0] sx,
                                 input logic [YW-1:0] sy, input logic [LW-1:0] lid,
                                 input logic [DW-1:0] exp_data, input bit check_latency);
        bit   accepted = 1'b0;
        exp_t e;
        link_in.fwd_v   = 1'b1;
        link_in.fwd_pkt = '{op: op, addr: addr, mask: mask, data: data,
                            src_y: sy, src_x: sx, load_id: lid};
        for (int i = 0; i < 200 && !accepted; i++) begin
            accepted = link_out.fwd_ready;
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no accept, expected accept of lid %0d", lid);
        end else begin
            e.pkt = '{rtype: op, data: exp_data, load_id: lid, dst_y: sy, dst_x: sx,
                      src_y: MY_Y, src_x: MY_X};
            e.due = check_latency ? cyc + 2 : -1;
            exp_q.push_back(e);
            last_accept = cyc;
            if (op && addr < AW'(ELS)) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask[b]) model_mem[addr[5:0]][8*b +: 8] = data[8*b +: 8];
                end
            end
        end
    endtask

    task automatic idleInput();
        link_in.fwd_v   = 1'b0;
        link_in.fwd_pkt = '0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic waitRevValid(input string name);
        for (int i = 0; i < 20 && !link_out.rev_v; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput(name, 64'(link_out.rev_v), 64'd1);
    endtask

    task automatic monitorResponses();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && link_out.rev_v && link_in.rev_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_response: got %h, expected none", link_out.rev_pkt);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("response", 64'(link_out.rev_pkt), 64'(e.pkt));
                    if (e.due >= 0) checkOutput("latency_cycle", 64'(cyc), 64'(e.due));
                end
            end
        end
    endtask

    initial begin
        link_in = '0;
        fork
            monitorResponses();
        join_none

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_fwd_ready", 64'(link_out.fwd_ready), 64'd0);
        checkOutput("reset_rev_v", 64'(link_out.rev_v), 64'd0);
        checkOutput("reset_rev_pkt", 64'(link_out.rev_pkt), 64'd0);
        checkOutput("reset_oob_count", 64'(oob_count), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        link_in.rev_ready = 1'b1;
        checkOutput("ready_after_reset", 64'(link_out.fwd_ready), 64'd1);

        // Store then load with two-cycle latency from an idle responder.
        applyStimulus(1'b1, 10'd5, 4'hF, 32'hDEADBEEF, 4'd2, 4'd1, 5'd3, 32'h0, 1'b1);
        idleInput();
        waitDrain();
        applyStimulus(1'b0, 10'd5, 4'hF, 32'h0, 4'd2, 4'd1, 5'd4, 32'hDEADBEEF, 1'b1);
        idleInput();
        waitDrain();

        // Byte-masked merge, plus a word used later by the out-of-range test.
        applyStimulus(1'b1, 10'd7, 4'hF, 32'h11223344, 4'd2, 4'd1, 5'd1, 32'h0, 1'b0);
        applyStimulus(1'b1, 10'd7, 4'b0101, 32'hAABBCCDD, 4'd2, 4'd1, 5'd2, 32'h0, 1'b0);
        applyStimulus(1'b0, 10'd7, 4'h0, 32'h0, 4'd2, 4'd1, 5'd6, 32'h11BB33DD, 1'b0);
        applyStimulus(1'b1, 10'd1, 4'hF, 32'hCAFEF00D, 4'd5, 4'd0, 5'd7, 32'h0, 1'b0);
        idleInput();
        waitDrain();

        // Back-pressure: one response held, then two accepts fill the FIFO.
        link_in.rev_ready = 1'b0;
        applyStimulus(1'b0, 10'd5, 4'hF, 32'h0, 4'd1, 4'd2, 5'd10, 32'hDEADBEEF, 1'b0);
        idleInput();
        waitRevValid("bp_first_valid");
        applyStimulus(1'b0, 10'd7, 4'hF, 32'h0, 4'd1, 4'd2, 5'd11, 32'h11BB33DD, 1'b0);
        applyStimulus(1'b0, 10'd1, 4'hF, 32'h0, 4'd1, 4'd2, 5'd12, 32'hCAFEF00D, 1'b0);
        checkOutput("bp_ready_drop", 64'(link_out.fwd_ready), 64'd0);
        fork
            begin
                applyStimulus(1'b0, 10'd5, 4'hF, 32'h0, 4'd1, 4'd2, 5'd13, 32'hDEADBEEF, 1'b0);
                idleInput();
            end
            begin
                held_bad = 0;
                repeat (4) begin
                    @(negedge clk);
                    if (!link_out.rev_v || link_out.rev_pkt !== exp_q[0].pkt) held_bad++;
                end
                checkOutput("bp_held_stable", 64'(held_bad), 64'd0);
                checkOutput("bp_ready_still_low", 64'(link_out.fwd_ready), 64'd0);
                @(posedge clk);
                #1;
                link_in.rev_ready = 1'b1;
            end
        join
        waitDrain();

        // Out-of-range load and store; addr 65 aliases word 1 if the guard is missing.
        applyStimulus(1'b0, 10'd64, 4'hF, 32'h0, 4'd2, 4'd3, 5'd20, 32'h0, 1'b0);
        applyStimulus(1'b1, 10'd65, 4'hF, 32'h12345678, 4'd2, 4'd3, 5'd21, 32'h0, 1'b0);
        applyStimulus(1'b0, 10'd1, 4'hF, 32'h0, 4'd2, 4'd3, 5'd22, 32'hCAFEF00D, 1'b0);
        idleInput();
        waitDrain();
        checkOutput("oob_count", 64'(oob_count), 64'd2);

        // Reset while a response is pending.
        link_in.rev_ready = 1'b0;
        applyStimulus(1'b0, 10'd7, 4'hF, 32'h0, 4'd2, 4'd3, 5'd23, 32'h11BB33DD, 1'b0);
        idleInput();
        waitRevValid("rst_resp_pending");
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_async_rev_v", 64'(link_out.rev_v), 64'd0);
        checkOutput("rst_async_oob_count", 64'(oob_count), 64'd0);
        checkOutput("rst_async_fwd_ready", 64'(link_out.fwd_ready), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        link_in.rev_ready = 1'b1;
        applyStimulus(1'b0, 10'd5, 4'hF, 32'h0, 4'd2, 4'd1, 5'd24, 32'hDEADBEEF, 1'b0);
        idleInput();
        waitDrain();

        // Streaming: seed a window of words, then 64 back-to-back random operations.
        for (int i = 16; i < 24; i++) begin
            applyStimulus(1'b1, AW'(i), 4'hF, $urandom, 4'd0, 4'd0, LW'(i), 32'h0, 1'b0);
        end
        idleInput();
        waitDrain();
        for (int k = 0; k < 64; k++) begin
            logic          op;
            logic [AW-1:0] addr;
            op   = 1'($urandom_range(0, 1));
            addr = AW'(16 + $urandom_range(0, 7));
            applyStimulus(op, addr, 4'($urandom), $urandom, 4'($urandom), 4'($urandom),
                          LW'(k), op ? 32'h0 : model_mem[addr[5:0]], 1'b0);
            acc_cyc[k] = last_accept;
        end
        idleInput();
        waitDrain();
        bad_intervals = 0;
        for (int k = 3; k < 64; k++) begin
            if (acc_cyc[k] - acc_cyc[k-1] != 2) bad_intervals++;
        end
        checkOutput("stream_accept_interval", 64'(bad_intervals), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
